// File: rtl/tlb_pkg.sv
// Shared constants and types for the translation lookaside buffer.
//   NUM_ENTRIES   : number of fully associative entries
//   VPN_W, PFN_W  : virtual page / physical frame number widths
//   PAGE_OFFSET_W : page offset bits below the VPN in a virtual address
package tlb_pkg;

  localparam int unsigned NUM_ENTRIES   = 8;
  localparam int unsigned VPN_W         = 20;
  localparam int unsigned PFN_W         = 20;
  localparam int unsigned PAGE_OFFSET_W = 12;
  localparam int unsigned ADDR_W        = VPN_W + PAGE_OFFSET_W;
  localparam int unsigned IDX_W         = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W         = 16;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/tlb_if.sv
// Lookup bus of the TLB: request, flattened entry table and translation result.
//   master : drives address/RW_in/is_mem_request and the entry vectors, reads the result
//   slave  : the TLB itself
// With TLB_STATS_EN defined the bus also carries hit_count / miss_count.
interface tlb_if;
  import tlb_pkg::*;

  logic [ADDR_W-1:0]            address;
  logic                         RW_in;
  logic                         is_mem_request;
  logic [NUM_ENTRIES*VPN_W-1:0] VP;
  logic [NUM_ENTRIES*PFN_W-1:0] PF;
  logic [NUM_ENTRIES-1:0]       entry_v;
  logic [NUM_ENTRIES-1:0]       entry_P;
  logic [NUM_ENTRIES-1:0]       entry_RW;
  logic [NUM_ENTRIES-1:0]       entry_PCD;
  logic [PFN_W-1:0]             PF_out;
  logic                         PCD_out;
  logic                         miss;
  logic                         hit;
  logic                         protection_exception;
`ifdef TLB_STATS_EN
  cnt_t                         hit_count;
  cnt_t                         miss_count;

  modport master (
    output address, RW_in, is_mem_request, VP, PF, entry_v, entry_P, entry_RW, entry_PCD,
    input  PF_out, PCD_out, miss, hit, protection_exception, hit_count, miss_count
  );
  modport slave (
    input  address, RW_in, is_mem_request, VP, PF, entry_v, entry_P, entry_RW, entry_PCD,
    output PF_out, PCD_out, miss, hit, protection_exception, hit_count, miss_count
  );
`else
  modport master (
    output address, RW_in, is_mem_request, VP, PF, entry_v, entry_P, entry_RW, entry_PCD,
    input  PF_out, PCD_out, miss, hit, protection_exception
  );
  modport slave (
    input  address, RW_in, is_mem_request, VP, PF, entry_v, entry_P, entry_RW, entry_PCD,
    output PF_out, PCD_out, miss, hit, protection_exception
  );
`endif

endinterface

// File: rtl/tlb_entry_cmp.sv
// Single-entry tag comparator.
//   i_vpn      : VPN of the current request
//   i_entry_vp : VPN stored in this entry
//   i_v, i_p   : entry valid / present
//   o_match    : valid entry whose VPN equals the request VPN
//   o_sel      : match on a present page, i.e. a usable translation
module tlb_entry_cmp
  import tlb_pkg::*;
(
  input  logic [VPN_W-1:0] i_vpn,
  input  logic [VPN_W-1:0] i_entry_vp,
  input  logic             i_v,
  input  logic             i_p,
  output logic             o_match,
  output logic             o_sel
);

  assign o_match = i_v & (i_entry_vp == i_vpn);
  assign o_sel   = o_match & i_p;

endmodule

// File: rtl/tlb.sv
// Fully associative TLB lookup for the memory stage. Purely combinational translation of
// address[31:12] against a flattened external entry table; lowest matching index wins.
//   clk, rst_n : clock / async active-low reset, used only by the statistics counters
//   bus        : tlb_if.slave (request, entry table, PF_out/PCD_out/miss/hit/
//                protection_exception)
// Optional feature: define TLB_STATS_EN to add saturating 16-bit hit_count / miss_count.
module tlb
  import tlb_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  tlb_if.slave bus
);

  logic [VPN_W-1:0]       w_vpn;
  logic [NUM_ENTRIES-1:0] w_match;
  logic [NUM_ENTRIES-1:0] w_sel;
  idx_t                   w_idx;
  logic                   w_any;
  logic                   w_miss;

  assign w_vpn = bus.address[ADDR_W-1:PAGE_OFFSET_W];

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cmp
    tlb_entry_cmp u_cmp (
      .i_vpn      (w_vpn),
      .i_entry_vp (bus.VP[g*VPN_W +: VPN_W]),
      .i_v        (bus.entry_v[g]),
      .i_p        (bus.entry_P[g]),
      .o_match    (w_match[g]),
      .o_sel      (w_sel[g])
    );
  end

  // Scan from the top down so the lowest selected index is the last one written.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_idx = idx_t'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_miss                   = bus.is_mem_request & ~w_any;
  assign bus.miss                 = w_miss;
  assign bus.hit                  = ~w_miss;
  assign bus.PF_out               = w_any ? bus.PF[w_idx*PFN_W +: PFN_W] : '0;
  assign bus.PCD_out              = w_any & bus.entry_PCD[w_idx];
  assign bus.protection_exception = bus.is_mem_request & bus.RW_in & w_any &
                                    ~bus.entry_RW[w_idx];

`ifdef TLB_STATS_EN
  cnt_t r_hit_count;
  cnt_t r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (bus.is_mem_request) begin
      if (!w_miss) begin
        if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
      end else begin
        if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
      end
    end
  end

  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

  logic w_unused_bits;
  assign w_unused_bits = ^{w_match, bus.address[PAGE_OFFSET_W-1:0]};
`else
  // Match vector and page offset are informational only; clk/rst_n feed nothing here.
  logic w_unused_bits;
  assign w_unused_bits = ^{w_match, bus.address[PAGE_OFFSET_W-1:0], clk, rst_n};
`endif

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: a reference model pushes expected lookups to a scoreboard
// queue as stimulus is driven; results are popped and compared once outputs settle.
module tb_tlb;
  import tlb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  tlb_if bus ();

  tlb u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [19:0]  pf;
    logic         pcd;
    logic         hit;
    logic         miss;
    logic         prot;
  } exp_t;

  exp_t        sb_q[$];
  logic [19:0] tb_vp[8];
  logic [19:0] tb_pf[8];
  logic [7:0]  tb_v, tb_p, tb_rw, tb_pcd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_entries();
    for (int i = 0; i < 8; i++) begin
      bus.VP[20*i +: 20] = tb_vp[i];
      bus.PF[20*i +: 20] = tb_pf[i];
    end
    bus.entry_v   = tb_v;
    bus.entry_P   = tb_p;
    bus.entry_RW  = tb_rw;
    bus.entry_PCD = tb_pcd;
  endtask

  // Reference: first usable entry in ascending order, straight from the tables.
  function automatic exp_t model(input string tag, input logic [31:0] a, input logic rw,
                                 input logic req);
    exp_t e;
    bit   found = 0;
    e.tag = tag; e.pf = '0; e.pcd = 0; e.prot = 0;
    for (int i = 0; i < 8; i++) begin
      if (!found && tb_v[i] && tb_p[i] && tb_vp[i] == a[31:12]) begin
        found  = 1;
        e.pf   = tb_pf[i];
        e.pcd  = tb_pcd[i];
        e.prot = req & rw & ~tb_rw[i];
      end
    end
    e.miss = req & !found;
    e.hit  = !e.miss;
    return e;
  endfunction

  task automatic lookup(input string tag, input logic [31:0] a, input logic rw,
                        input logic req);
    exp_t e;
    bus.address        = a;
    bus.RW_in          = rw;
    bus.is_mem_request = req;
    sb_q.push_back(model(tag, a, rw, req));
    #2;
    e = sb_q.pop_front();
    check({e.tag, ".pf"},   32'(bus.PF_out),               32'(e.pf));
    check({e.tag, ".pcd"},  32'(bus.PCD_out),              32'(e.pcd));
    check({e.tag, ".hit"},  32'(bus.hit),                  32'(e.hit));
    check({e.tag, ".miss"}, 32'(bus.miss),                 32'(e.miss));
    check({e.tag, ".prot"}, 32'(bus.protection_exception), 32'(e.prot));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    tb_vp  = '{20'h00000, 20'h02000, 20'h04000, 20'h0b000,
               20'h0c000, 20'h0a000, 20'h06000, 20'h03000};
    tb_pf  = '{20'h00000, 20'h00002, 20'h00005, 20'h00004,
               20'h00007, 20'h00005, 20'h00006, 20'h00003};
    tb_v   = 8'b10111111;
    tb_p   = 8'b11110111;
    tb_rw  = 8'b11010101;
    tb_pcd = 8'b00000011;
    load_entries();
    bus.address = '0; bus.RW_in = 0; bus.is_mem_request = 0;

    // Lookup is live even while reset is held.
    #1;
    lookup("in_reset", 32'h00000123, 1'b0, 1'b1);
`ifdef TLB_STATS_EN
    check("rst.hit_count",  32'(bus.hit_count),  32'd0);
    check("rst.miss_count", 32'(bus.miss_count), 32'd0);
`endif
    @(posedge clk); #1;
    bus.is_mem_request = 0;
    rst_n = 1'b1;

`ifdef TLB_STATS_EN
    // Hit, miss, hit: each request spans exactly one rising edge.
    @(posedge clk); #1;
    lookup("st_hit1", 32'h0a000777, 1'b0, 1'b1);
    @(posedge clk); #1;
    lookup("st_miss", 32'hFFFFFFFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    lookup("st_hit2", 32'h00000123, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.is_mem_request = 0;
    check("st.hit_count",  32'(bus.hit_count),  32'd2);
    check("st.miss_count", 32'(bus.miss_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("st_rst.hit_count",  32'(bus.hit_count),  32'd0);
    check("st_rst.miss_count", 32'(bus.miss_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Preset near the top, then keep hitting past saturation.
    force u_dut.r_hit_count = 16'hFFFD;
    #1 release u_dut.r_hit_count;
    bus.address = 32'h03000AAA; bus.RW_in = 0; bus.is_mem_request = 1;
    repeat (5) @(posedge clk);
    #1 bus.is_mem_request = 0;
    check("sat.hit_count",  32'(bus.hit_count),  32'hFFFF);
    check("sat.miss_count", 32'(bus.miss_count), 32'd0);
`endif

    lookup("no_req",      32'h03000AAA, 1'b1, 1'b0);
    lookup("not_present", 32'h0b000234, 1'b0, 1'b1);
    lookup("unmapped",    32'hFFFFFFFF, 1'b1, 1'b1);
    lookup("unmapped_nr", 32'hFFFFFFFF, 1'b1, 1'b0);
    lookup("not_valid",   32'h06000432, 1'b1, 1'b1);
    lookup("wr_prot",     32'h0a000777, 1'b1, 1'b1);
    lookup("rd_prot",     32'h0a000777, 1'b0, 1'b1);
    lookup("pcd_e0",      32'h00000123, 1'b0, 1'b1);
    lookup("wr_ok",       32'h0c000fff, 1'b1, 1'b1);
    lookup("nr_prot",     32'h0a000777, 1'b1, 1'b0);

    // Duplicate VPNs: entries 2, 4 and 6 all map 0x04000 with differing attributes.
    tb_vp[4] = 20'h04000; tb_vp[6] = 20'h04000;
    tb_pf[2] = 20'h0ABCD; tb_pf[4] = 20'h01234; tb_pf[6] = 20'h0FFFF;
    tb_pcd = 8'b01010011;
    load_entries();
    lookup("dup_low",  32'h04000010, 1'b1, 1'b1);
    tb_p[2] = 1'b0;
    load_entries();
    lookup("dup_next", 32'h04000010, 1'b1, 1'b1);

    // Random sweep over mapped and unmapped pages.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      a = $urandom();
      if (n % 3 != 0) a[31:12] = tb_vp[$urandom_range(7, 0)];
      lookup($sformatf("rnd%0d", n), a, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
